// File: rtl/i2c_reg_slave.sv
// I2C target exposing an N_REGS-deep byte register window at a fixed 7-bit address.
// Supports pointer writes, auto-incrementing burst writes and wrapping burst reads.
module i2c_reg_slave #(
  parameter logic [6:0] I2C_ADDR    = 7'h64,
  parameter int         N_REGS      = 8,
  parameter int         SYNC_STAGES = 3,
  localparam int        PTR_W       = (N_REGS > 2) ? $clog2(N_REGS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scl,
  input  logic                sda_in,
  output logic                sda_oe,
  output logic                sda_out,
  input  logic [8*N_REGS-1:0] rd_regs,
  output logic                wr_en,
  output logic [PTR_W-1:0]    wr_addr,
  output logic [7:0]          wr_data,
  output logic                busy
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR_BYTE,
    WR_BYTE,
    DATA_ACK,
    RD_BYTE,
    RD_MACK,
    WAIT_STOP
  } state_t;

  localparam logic [8:0]       N_REGS_9 = 9'(N_REGS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REGS - 1);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       bit_cnt;
  logic [3:0]       cnt_nxt;
  logic [7:0]       shreg;
  logic [7:0]       shreg_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] ptr_inc;
  logic             oe_nxt;
  logic             busy_nxt;
  logic             wr_en_nxt;
  logic [PTR_W-1:0] wr_addr_nxt;
  logic [7:0]       wr_data_nxt;

  logic [7:0] rx_byte;
  logic [7:0] rd_byte;
  logic       addr_match;
  logic       ptr_ok;

  assign sda_out = 1'b0;

  // Bus lines idle high, so the synchronisers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-2];
  assign sda_s     = sda_sync[SYNC_STAGES-2];
  assign scl_rise  = scl_sync[SYNC_STAGES-2] & ~scl_sync[SYNC_STAGES-1];
  assign scl_fall  = ~scl_sync[SYNC_STAGES-2] & scl_sync[SYNC_STAGES-1];
  assign start_det = scl_s & ~sda_sync[SYNC_STAGES-2] & sda_sync[SYNC_STAGES-1];
  assign stop_det  = scl_s & sda_sync[SYNC_STAGES-2] & ~sda_sync[SYNC_STAGES-1];

  assign rx_byte    = {shreg[6:0], sda_s};
  assign rd_byte    = rd_regs[{ptr, 3'b000} +: 8];
  assign addr_match = (shreg[7:1] == I2C_ADDR);
  assign ptr_ok     = ({1'b0, shreg} < N_REGS_9);
  assign ptr_inc    = (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
      shreg   <= shreg_nxt;
      ptr     <= ptr_nxt;
      sda_oe  <= oe_nxt;
      busy    <= busy_nxt;
      wr_en   <= wr_en_nxt;
      wr_addr <= wr_addr_nxt;
      wr_data <= wr_data_nxt;
    end
  end

  // Receive states shift on scl_rise; every SDA drive change is made on an scl_fall.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = bit_cnt;
    shreg_nxt   = shreg;
    ptr_nxt     = ptr;
    oe_nxt      = sda_oe;
    busy_nxt    = busy;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;

    if (start_det) begin
      state_nxt = ADDR;
      cnt_nxt   = '0;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b1;
    end else if (stop_det) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        ADDR, PTR_BYTE, WR_BYTE: begin
          if (scl_rise && (bit_cnt < 4'd8)) begin
            shreg_nxt = rx_byte;
            cnt_nxt   = bit_cnt + 4'd1;
            if ((state == WR_BYTE) && (bit_cnt == 4'd7)) begin
              wr_en_nxt   = 1'b1;
              wr_addr_nxt = ptr;
              wr_data_nxt = rx_byte;
              ptr_nxt     = ptr_inc;
            end
          end else if (scl_fall && (bit_cnt == 4'd8)) begin
            cnt_nxt = '0;
            case (state)
              ADDR: begin
                if (addr_match) begin
                  state_nxt = ADDR_ACK;
                  oe_nxt    = 1'b1;
                end else begin
                  state_nxt = WAIT_STOP;
                end
              end
              PTR_BYTE: begin
                if (ptr_ok) begin
                  ptr_nxt   = shreg[PTR_W-1:0];
                  state_nxt = DATA_ACK;
                  oe_nxt    = 1'b1;
                end else begin
                  state_nxt = WAIT_STOP;
                end
              end
              default: begin
                state_nxt = DATA_ACK;
                oe_nxt    = 1'b1;
              end
            endcase
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_nxt = '0;
            if (shreg[0]) begin
              shreg_nxt = rd_byte;
              oe_nxt    = ~rd_byte[7];
              state_nxt = RD_BYTE;
            end else begin
              oe_nxt    = 1'b0;
              state_nxt = PTR_BYTE;
            end
          end
        end

        DATA_ACK: begin
          if (scl_fall) begin
            cnt_nxt   = '0;
            oe_nxt    = 1'b0;
            state_nxt = WR_BYTE;
          end
        end

        // bit_cnt here counts bits already clocked out by the master.
        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd7) begin
              cnt_nxt   = '0;
              oe_nxt    = 1'b0;
              ptr_nxt   = ptr_inc;
              state_nxt = RD_MACK;
            end else begin
              cnt_nxt   = bit_cnt + 4'd1;
              shreg_nxt = {shreg[6:0], 1'b0};
              oe_nxt    = ~shreg[6];
            end
          end
        end

        RD_MACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_nxt = WAIT_STOP;
            end else begin
              cnt_nxt = 4'd1;
            end
          end else if (scl_fall && (bit_cnt == 4'd1)) begin
            cnt_nxt   = '0;
            shreg_nxt = rd_byte;
            oe_nxt    = ~rd_byte[7];
            state_nxt = RD_BYTE;
          end
        end

        default: begin
          oe_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_reg_slave.md
# i2c_reg_slave

Parametrised I2C target exposing an `N_REGS`-deep byte register window at a fixed 7-bit address. It supports master writes (register pointer plus auto-incrementing data writes), master reads (auto-incrementing, wrapping), repeated START and STOP handling, and NACK of out-of-range pointers. It replaces the fixed three-byte read-only target on the sensor/status port. The host-visible register contents come from a flat read bus, and writes leave the block as a one-cycle strobe.

## Interface
- `I2C_ADDR`, default 7'h64: target address.
- `N_REGS`, default 8: register count, 2..256. `PTR_W = max(1, clog2(N_REGS))` is derived.
- `SYNC_STAGES`, default 3: synchroniser depth on SCL and SDA, minimum 2.

Ports:
- `clk` input 1: system clock. Must be at least 16x the SCL frequency.
- `rst_n` input 1: reset, asynchronous, active-low.
- `scl` input 1: bus clock (asynchronous).
- `sda_in` input 1: bus data (asynchronous).
- `sda_oe` output 1: 1 pulls SDA low, 0 releases it.
- `sda_out` output 1: constant 0 (open-drain).
- `rd_regs` input 8*N_REGS: register i occupies bits [8i+7:8i].
- `wr_en` output 1: one-cycle write strobe.
- `wr_addr` output PTR_W: write register index.
- `wr_data` output 8: write data.
- `busy` output 1: high from START detect until STOP detect.

## Operation
- **Synchronisers.** SCL and SDA each pass through `SYNC_STAGES` flops.
  - A rise or fall is detected when the last two stages differ.
  - START is detected when synced SDA falls while synced SCL is high.
  - STOP is detected when synced SDA rises while synced SCL is high.
- **Input sampling.** All bus sampling uses synced SDA on the `scl_rise` detect cycle.
- **Pointer.** `ptr` is a PTR_W-bit register with reset value 0. It persists across transactions.
- **State machine.** States are IDLE, ADDR, ADDR_ACK, PTR_BYTE, WR_BYTE, DATA_ACK, RD_BYTE, RD_MACK, WAIT_STOP.
- **Global transitions.**
  - START in any state goes to ADDR and clears the bit count. This covers repeated START.
  - STOP in any state goes to IDLE, releases SDA, and clears `busy`.
- **ADDR.** Shifts in 8 bits MSB-first.
  - If addr[7:1] == I2C_ADDR, go to ADDR_ACK.
  - Otherwise go to WAIT_STOP with SDA never driven.
- **ADDR_ACK.** Drives ACK, then branches on R/W:
  - R/W = 0 goes to PTR_BYTE.
  - R/W = 1 loads the shift register with `rd_regs[ptr]` and goes to RD_BYTE.
- **PTR_BYTE.** Shifts in 8 bits.
  - If the value is < N_REGS, `ptr` takes the value, the block ACKs, and goes to WR_BYTE.
  - Otherwise the block NACKs (SDA released through the 9th clock), leaves `ptr` unchanged, and goes to WAIT_STOP.
- **WR_BYTE.** Shifts in 8 bits.
  - On the 8th-bit `scl_rise` detect: `wr_en` = 1 for one cycle, `wr_addr` = `ptr`, `wr_data` = the byte.
  - In the same cycle, `ptr` increments, wrapping from N_REGS-1 to 0.
  - Then goes to DATA_ACK, which ACKs and returns to WR_BYTE.
- **RD_BYTE.** Drives 8 bits MSB-first.
  - A 0 bit asserts `sda_oe`. A 1 bit releases it.
  - After the 8th bit's `scl_fall`, `ptr` increments (with wrap), SDA is released, and the state goes to RD_MACK.
- **RD_MACK.** Samples the master's ACK bit.
  - SDA = 0 (ACK): load `rd_regs[ptr]` and go to RD_BYTE at the following `scl_fall`.
  - SDA = 1 (NACK): go to WAIT_STOP.
- **WAIT_STOP.** SDA is released. Waits for STOP or START; all other bus activity is ignored.

## Timing
- **Reset values.** `sda_oe`=0, `sda_out`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `ptr`=0, state IDLE.
- **Reset assertion.** Reset takes effect immediately, including mid-byte. SDA is released combinationally via the `sda_oe` flop reset.
- **Edge detect latency.** Bus edges are seen SYNC_STAGES to SYNC_STAGES+1 clk after the pin changes.
- **SDA drive changes.** Changes only on the cycle after an `scl_fall` detect, never while synced SCL is high.
- **ACK window.** `sda_oe` rises 1 clk after the 8th bit's `scl_fall` detect and falls 1 clk after the 9th bit's `scl_fall` detect.
- **Read data sampling.** The `rd_regs` byte is sampled once, at load time. Later changes do not affect a byte in flight.
- **`busy`.** Rises 1 clk after START detect and falls 1 clk after STOP detect.
- **Simultaneous events.** A `wr_en` pulse and a STOP detect cannot coincide: the strobe precedes the ACK clock. START/STOP take priority over bit processing in the same cycle.

## Test plan
- **Pointer write with auto-increment.** Write 0xC8, 0x02, 0xA5, 0x3C, then STOP.
  - ACK on all four 9th clocks.
  - `wr_en` pulses with (2, 0xA5) then (3, 0x3C).
  - `ptr` = 4 afterwards.
- **Read with wrap.** Set `rd_regs[i]` = 0x10+i and ptr = 6. Read 3 bytes (ACK, ACK, NACK).
  - Bytes received are 0x16, 0x17, 0x10.
  - `ptr` = 1 afterwards.
- **Combined write/read via repeated START.** Write ptr 0x05, repeated START, 0xC9, read 1 byte with NACK, STOP.
  - Byte received is 0x15.
  - `ptr` = 6, no `wr_en`, `busy` low after STOP.
- **Address mismatch.** Send address 0x46 (7'h23) followed by 2 data bytes.
  - `sda_oe` stays 0 throughout and `wr_en` never pulses.
  - The next START to 0x64 is ACKed normally.
- **Out-of-range pointer.** Write ptr 0x09 with N_REGS = 8.
  - NACK on the 9th clock and `ptr` unchanged.
  - A following data byte 0xFF causes no `wr_en` and no ACK.
- **Reset mid-read.** Assert `rst_n` low during bit 4 of a read of a 0x00 byte.
  - `sda_oe` = 0 within the same cycle and `ptr` = 0.
  - After release, a fresh write transaction ACKs and strobes correctly.
